dmem_arbiter: RTL and testbench

Two-requester arbiter that shares the single data-memory port between the CPU load/store path and the VGA display-fetch engine. It sits between the CPU bus decode (`MemType == DATA` accesses) and `data_mem`, and owns the memory address, write-enable, write-data and `MemOp` pins. Each access runs as a fixed 3-cycle transaction. Ties use round-robin arbitration, and an urgent display request overrides round-robin.

---
 rtl/dmem_arb_pkg.sv | 6 +
 rtl/dmem_arbiter.sv | 69 ++++++
 tb/tb_dmem_arbiter.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared types and constants for the data-memory arbiter.
package dmem_arb_pkg;
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} arb_state_t;
    typedef enum logic {OWN_CPU, OWN_VGA} arb_owner_t;
    localparam logic [2:0] MEMOP_WORD = 3'b010;
endpackage

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the data-memory port between CPU and VGA fetch,
// fixed 3-cycle transactions, round-robin ties, urgent VGA overrides.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    input  logic [2:0]        cpu_memop,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              vga_req,
    input  logic              vga_urgent,
    input  logic [ADDR_W-1:0] vga_addr,
    output logic              vga_ack,
    output logic [DATA_W-1:0] vga_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [2:0]        mem_memop,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);
    arb_state_t state, state_next;
    arb_owner_t owner, last_grant, winner;
    logic any_req;

    always_comb begin
        any_req    = cpu_req | vga_req;
        winner     = (vga_req && (vga_urgent || !cpu_req || last_grant == OWN_CPU)) ? OWN_VGA : OWN_CPU;
        state_next = (state == IDLE) ? (any_req ? ACCESS : IDLE) : (state == ACCESS) ? RESP : IDLE;
        busy       = state != IDLE;
        cpu_ack    = state == RESP && owner == OWN_CPU;
        vga_ack    = state == RESP && owner == OWN_VGA;
        cpu_rdata  = cpu_ack ? mem_rdata : '0;
        vga_rdata  = vga_ack ? mem_rdata : '0;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            owner      <= OWN_CPU;
            last_grant <= OWN_VGA;
            mem_addr   <= '0;
            mem_we     <= 1'b0;
            mem_wdata  <= '0;
            mem_memop  <= '0;
        end else begin
            state <= state_next;
            if (state == IDLE && any_req) begin
                owner      <= winner;
                last_grant <= winner;
                mem_addr   <= (winner == OWN_VGA) ? vga_addr : cpu_addr;
                mem_we     <= winner == OWN_CPU && cpu_we;
                mem_wdata  <= (winner == OWN_VGA) ? '0 : cpu_wdata;
                mem_memop  <= (winner == OWN_VGA) ? MEMOP_WORD : cpu_memop;
            end else if (state == ACCESS) begin
                // write strobe is confined to the single ACCESS cycle
                mem_we <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: scoreboard bench for dmem_arbiter with a behavioural
// data memory that returns read data one cycle after the address.
module tb_dmem_arbiter;
    import dmem_arb_pkg::*;

    typedef struct {
        logic        vga;
        logic        chk;
        logic [31:0] data;
        int          gap;
    } exp_t;

    logic        clock = 0, reset = 0;
    logic        cpu_req = 0, cpu_we = 0, vga_req = 0, vga_urgent = 0;
    logic [31:0] cpu_addr = 0, cpu_wdata = 0, vga_addr = 0;
    logic [2:0]  cpu_memop = 0;
    logic        cpu_ack, vga_ack, mem_we, busy;
    logic [31:0] cpu_rdata, vga_rdata, mem_addr, mem_wdata;
    logic [31:0] mem_rdata = 0;
    logic [2:0]  mem_memop;

    int   n_tests = 0, n_fail = 0, cyc = 0, last_ack = 0, lat_c = 0, lat_v = 0;
    exp_t sb[$];
    logic [31:0] mem_model [logic [31:0]];

    dmem_arbiter dut (
        .clock(clock), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_memop(cpu_memop), .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .vga_req(vga_req), .vga_urgent(vga_urgent), .vga_addr(vga_addr),
        .vga_ack(vga_ack), .vga_rdata(vga_rdata),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_memop(mem_memop),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc++;

    function automatic logic [31:0] pat(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    always @(posedge clock) begin
        mem_rdata <= mem_model.exists(mem_addr) ? mem_model[mem_addr] : pat(mem_addr);
        if (mem_we) mem_model[mem_addr] = mem_wdata;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h @cyc %0d", tag, got, exp, cyc);
        end
    endtask

    task automatic ack_event(input logic is_vga, input logic [31:0] rd);
        exp_t e;
        if (sb.size() == 0) check(is_vga ? "vga_ack_unexpected" : "cpu_ack_unexpected", 1, 0);
        else begin
            e = sb.pop_front();
            check("ack_owner", is_vga, e.vga);
            if (e.chk) check(is_vga ? "vga_rdata" : "cpu_rdata", rd, e.data);
            if (e.gap != 0) check("ack_gap", cyc - last_ack, e.gap);
        end
        last_ack = cyc;
    endtask

    always @(negedge clock) begin
        if (cpu_ack) begin
            ack_event(1'b0, cpu_rdata);
            check("vga_rdata_nonowner", vga_rdata, 0);
        end
        if (vga_ack) begin
            ack_event(1'b1, vga_rdata);
            check("cpu_rdata_nonowner", cpu_rdata, 0);
        end
    end

    task automatic push(input logic v, input logic c, input logic [31:0] d, input int g);
        exp_t e;
        e.vga = v; e.chk = c; e.data = d; e.gap = g;
        sb.push_back(e);
    endtask

    task automatic cpu_op(input logic we, input logic [31:0] a, input logic [31:0] d,
                          input logic [2:0] op, output int lat);
        cpu_req = 1; cpu_we = we; cpu_addr = a; cpu_wdata = d; cpu_memop = op;
        lat = 0;
        for (int i = 1; i <= 20 && lat == 0; i++) begin
            @(negedge clock);
            if (cpu_ack) lat = i;
        end
        if (lat == 0) check("cpu_timeout", 0, 1);
        cpu_req = 0;
    endtask

    task automatic vga_op(input logic [31:0] a, output int lat);
        vga_req = 1; vga_addr = a;
        lat = 0;
        for (int i = 1; i <= 20 && lat == 0; i++) begin
            @(negedge clock);
            if (vga_ack) lat = i;
        end
        if (lat == 0) check("vga_timeout", 0, 1);
        vga_req = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired @cyc %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        #1 reset = 1;
        repeat (2) @(negedge clock);
        check("rst_busy", busy, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_mem_memop", mem_memop, 0);
        check("rst_cpu_ack", cpu_ack, 0);
        check("rst_vga_ack", vga_ack, 0);
        reset = 0;
        @(negedge clock);

        // CPU write, inputs disturbed during ACCESS
        push(1'b0, 1'b0, 0, 0);
        cpu_req = 1; cpu_we = 1; cpu_addr = 32'h10; cpu_wdata = 32'hDEADBEEF; cpu_memop = 3'b010;
        @(negedge clock);
        check("wr_access_we", mem_we, 1);
        check("wr_access_addr", mem_addr, 32'h10);
        check("wr_access_wdata", mem_wdata, 32'hDEADBEEF);
        check("wr_access_memop", mem_memop, 3'b010);
        check("wr_access_busy", busy, 1);
        check("wr_access_ack", cpu_ack, 0);
        cpu_addr = 32'h20; cpu_wdata = 32'h12345678;
        @(negedge clock);
        check("wr_resp_we", mem_we, 0);
        check("wr_resp_ack", cpu_ack, 1);
        check("wr_hold_addr", mem_addr, 32'h10);
        check("wr_hold_wdata", mem_wdata, 32'hDEADBEEF);
        cpu_req = 0;
        @(negedge clock);
        push(1'b0, 1'b1, 32'hDEADBEEF, 0);
        cpu_op(0, 32'h10, 0, 3'b010, lat_c);
        check("rd_latency", lat_c, 2);

        // simultaneous requests after reset: CPU, VGA, CPU, VGA
        @(negedge clock);
        reset = 1;
        @(negedge clock);
        reset = 0;
        push(1'b0, 1'b1, 32'hDEADBEEF, 0);
        push(1'b1, 1'b1, pat(32'h100), 3);
        push(1'b0, 1'b1, pat(32'h14), 3);
        push(1'b1, 1'b1, pat(32'h104), 3);
        fork
            begin cpu_op(0, 32'h10, 0, 3'b010, lat_c); cpu_op(0, 32'h14, 0, 3'b010, lat_c); end
            begin vga_op(32'h100, lat_v); vga_op(32'h104, lat_v); end
        join

        // urgent VGA beats round-robin that would favour the CPU
        @(negedge clock);
        vga_urgent = 1;
        push(1'b1, 1'b1, pat(32'h108), 0);
        push(1'b0, 1'b0, 0, 3);
        fork
            vga_op(32'h108, lat_v);
            cpu_op(1, 32'h200, 32'h0BADF00D, 3'b000, lat_c);
            begin
                @(negedge clock);
                check("urg_memop", mem_memop, 3'b010);
                check("urg_we", mem_we, 0);
                check("urg_addr", mem_addr, 32'h108);
            end
        join

        // urgent without vga_req is ignored
        @(negedge clock);
        push(1'b0, 1'b1, 32'h0BADF00D, 0);
        cpu_op(0, 32'h200, 0, 3'b010, lat_c);
        check("urg_noreq_latency", lat_c, 2);
        vga_urgent = 0;

        // reset during ACCESS of a CPU write aborts it
        @(negedge clock);
        cpu_req = 1; cpu_we = 1; cpu_addr = 32'h40; cpu_wdata = 32'hCAFEF00D; cpu_memop = 3'b010;
        @(negedge clock);
        check("abort_pre_we", mem_we, 1);
        #1 reset = 1;
        #1;
        check("abort_we", mem_we, 0);
        check("abort_busy", busy, 0);
        check("abort_ack", cpu_ack, 0);
        check("abort_addr", mem_addr, 0);
        cpu_req = 0;
        repeat (2) @(negedge clock);
        reset = 0;
        @(negedge clock);
        push(1'b0, 1'b1, pat(32'h40), 0);
        cpu_op(0, 32'h40, 0, 3'b010, lat_c);
        check("post_abort_latency", lat_c, 2);
        push(1'b0, 1'b0, 0, 0);
        cpu_op(1, 32'h40, 32'hCAFEF00D, 3'b010, lat_c);
        push(1'b0, 1'b1, 32'hCAFEF00D, 0);
        cpu_op(0, 32'h40, 0, 3'b010, lat_c);

        repeat (4) @(negedge clock);
        check("sb_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
